// File: rtl/frame_writer_if.sv
// Avalon-MM write bus between the frame writer and the SDRAM write port.
// The master side drives the write slot; the slave side only stalls it.
interface frame_writer_if;
    logic [28:0] address;
    logic [7:0]  burstcount;
    logic        waitrequest;
    logic [63:0] writedata;
    logic [7:0]  byteenable;
    logic        write;

    modport master (
        output address,
        output burstcount,
        output writedata,
        output byteenable,
        output write,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  burstcount,
        input  writedata,
        input  byteenable,
        input  write,
        output waitrequest
    );
endinterface

// File: rtl/frame_writer.sv
// Frame writer: packs 32-bit rasterizer pixels into 64-bit SDRAM words for the
// back buffer and performs solid-colour buffer clears. One pending word
// collects lane pairs; it is written when a pixel for another word arrives,
// on flush, after an idle timeout, or before a clear starts.
module frame_writer #(
    parameter int unsigned ADDRESS      = 0,
    parameter int unsigned LENGTH       = 0,
    parameter int unsigned FLUSH_CYCLES = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    frame_writer_if.master bus,
    input  logic           back_buffer,
    input  logic           pixel_valid,
    output logic           pixel_ready,
    input  logic [23:0]    pixel_index,
    input  logic [31:0]    pixel_color,
    input  logic           flush,
    input  logic           clear_start,
    input  logic [31:0]    clear_color,
    output logic           clear_busy,
    output logic [31:0]    debug_value
);

    localparam logic [28:0] BASE_WORD   = 29'(ADDRESS / 8);
    localparam logic [28:0] BUF_WORDS   = 29'(LENGTH / 8);
    localparam logic [31:0] BUF_PIXELS  = 32'(LENGTH / 4);
    localparam logic [31:0] FLUSH_LIMIT = 32'(FLUSH_CYCLES);

    typedef enum logic [1:0] {PIXEL, DRAIN, CLEAR} state_t;

    state_t state;
    state_t state_next;

    // Output slot registers
    logic        wr_q;
    logic [28:0] addr_q;
    logic [63:0] data_q;
    logic [7:0]  be_q;

    // Pending (partially filled) word
    logic        pend_valid;
    logic [28:0] pend_addr;
    logic [63:0] pend_data;
    logic [7:0]  pend_be;
    logic [31:0] idle_cnt;

    // Clear sequencer
    logic [31:0] clr_color;
    logic [28:0] clr_base;
    logic [28:0] clr_cnt;

    logic [31:0] write_count;
    logic        running;

    logic        slot_free;
    logic        accept;
    logic        in_range;
    logic        same_word;
    logic        lane;
    logic [28:0] pix_addr;
    logic [63:0] lane_data;
    logic [7:0]  lane_be;

    logic        issue;
    logic [28:0] issue_addr;
    logic [63:0] issue_data;
    logic [7:0]  issue_be;
    logic        pend_drop;
    logic        clear_go;
    logic        clear_step;
    logic        clear_end;

    assign slot_free   = !wr_q || !bus.waitrequest;
    assign pixel_ready = running && (state == PIXEL) && slot_free;
    assign accept      = pixel_valid && pixel_ready;
    assign in_range    = {8'd0, pixel_index} < BUF_PIXELS;
    assign lane        = pixel_index[0];
    assign pix_addr    = BASE_WORD + (back_buffer ? BUF_WORDS : 29'd0)
                       + {6'd0, pixel_index[23:1]};
    assign lane_data   = lane ? {pixel_color, 32'd0} : {32'd0, pixel_color};
    assign lane_be     = lane ? 8'hF0 : 8'h0F;
    assign same_word   = pend_valid && (pend_addr == pix_addr);

    assign bus.address    = addr_q;
    assign bus.writedata  = data_q;
    assign bus.byteenable = be_q;
    assign bus.write      = wr_q;
    assign bus.burstcount = 8'h01;
    assign debug_value    = write_count;

    // Holds pixel_ready low until the first clock after reset is released
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) running <= 1'b0;
        else          running <= 1'b1;
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= PIXEL;
        else          state <= state_next;
    end

    // Next-state logic and selection of the word to place in the output slot
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        issue_addr = '0;
        issue_data = '0;
        issue_be   = '0;
        pend_drop  = 1'b0;
        clear_go   = 1'b0;
        clear_step = 1'b0;
        clear_end  = 1'b0;
        case (state)
            PIXEL: begin
                if (accept) begin
                    if (in_range && pend_valid && !same_word) begin
                        issue      = 1'b1;
                        issue_addr = pend_addr;
                        issue_data = pend_data;
                        issue_be   = pend_be;
                    end
                end else if (pend_valid && slot_free &&
                             (flush || idle_cnt >= FLUSH_LIMIT)) begin
                    issue      = 1'b1;
                    issue_addr = pend_addr;
                    issue_data = pend_data;
                    issue_be   = pend_be;
                    pend_drop  = 1'b1;
                end
                if (clear_start) begin
                    clear_go   = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!pend_valid) begin
                    state_next = CLEAR;
                end else if (slot_free) begin
                    issue      = 1'b1;
                    issue_addr = pend_addr;
                    issue_data = pend_data;
                    issue_be   = pend_be;
                    pend_drop  = 1'b1;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_cnt != BUF_WORDS) begin
                    if (slot_free) begin
                        issue      = 1'b1;
                        issue_addr = clr_base + clr_cnt;
                        issue_data = {clr_color, clr_color};
                        issue_be   = 8'hFF;
                        clear_step = 1'b1;
                    end
                end else if (slot_free) begin
                    clear_end  = 1'b1;
                    state_next = PIXEL;
                end
            end
            default: state_next = PIXEL;
        endcase
    end

    // Output slot: load a new word, drop write after acceptance, else hold
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            be_q   <= '0;
        end else if (issue) begin
            wr_q   <= 1'b1;
            addr_q <= issue_addr;
            data_q <= issue_data;
            be_q   <= issue_be;
        end else if (slot_free) begin
            wr_q   <= 1'b0;
        end
    end

    // Pending word: merge same-word pixels, replace on a new word, empty on drain
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            pend_be    <= '0;
        end else if (accept && in_range) begin
            if (same_word) begin
                if (lane) pend_data[63:32] <= pixel_color;
                else      pend_data[31:0]  <= pixel_color;
                pend_be <= pend_be | lane_be;
            end else begin
                pend_valid <= 1'b1;
                pend_addr  <= pix_addr;
                pend_data  <= lane_data;
                pend_be    <= lane_be;
            end
        end else if (pend_drop) begin
            pend_valid <= 1'b0;
        end
    end

    // Idle timer since the last accepted pixel, saturating at the flush limit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                                  idle_cnt <= '0;
        else if (accept)                               idle_cnt <= '0;
        else if (pend_valid && idle_cnt < FLUSH_LIMIT) idle_cnt <= idle_cnt + 32'd1;
    end

    // Clear parameters captured at start, word counter advanced per issued word
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clr_color  <= '0;
            clr_base   <= '0;
            clr_cnt    <= '0;
            clear_busy <= 1'b0;
        end else begin
            if (clear_go) begin
                clr_color  <= clear_color;
                clr_base   <= BASE_WORD + (back_buffer ? BUF_WORDS : 29'd0);
                clr_cnt    <= '0;
                clear_busy <= 1'b1;
            end else if (clear_step) begin
                clr_cnt <= clr_cnt + 29'd1;
            end
            if (clear_end) clear_busy <= 1'b0;
        end
    end

    // Count of writes accepted by the memory controller
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                    write_count <= '0;
        else if (wr_q && !bus.waitrequest) write_count <= write_count + 32'd1;
    end

endmodule

// File: tb/tb_frame_writer.sv
// Testbench for frame_writer: directed scenarios plus a randomized run whose
// result is compared as a memory image against a pixel-level reference model.
module tb_frame_writer;

    localparam int unsigned LENGTH = 64;
    localparam int unsigned FLUSH  = 4;

    typedef struct {
        logic [28:0] a;
        logic [63:0] d;
        logic [7:0]  be;
        int          c;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        back_buffer = 1'b0;
    logic        pixel_valid = 1'b0;
    logic        pixel_ready;
    logic [23:0] pixel_index = '0;
    logic [31:0] pixel_color = '0;
    logic        flush = 1'b0;
    logic        clear_start = 1'b0;
    logic [31:0] clear_color = '0;
    logic        clear_busy;
    logic [31:0] debug_value;

    logic        stall = 1'b0;
    logic        rand_wait = 1'b0;
    logic        wait_line = 1'b0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          n_checks = 0;
    int          n_fails = 0;
    logic [31:0] dbg0;
    wr_t         obs[$];

    logic [63:0] m_data[int];
    logic [7:0]  m_be[int];
    logic [63:0] d_data[int];
    logic [7:0]  d_be[int];

    frame_writer_if bus();

    assign bus.waitrequest = wait_line;

    frame_writer #(
        .ADDRESS(0),
        .LENGTH(LENGTH),
        .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus),
        .back_buffer(back_buffer),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .pixel_index(pixel_index),
        .pixel_color(pixel_color),
        .flush(flush),
        .clear_start(clear_start),
        .clear_color(clear_color),
        .clear_busy(clear_busy),
        .debug_value(debug_value)
    );

    // Free-running clock
    always #5 clock = ~clock;

    // Cycle counter used for latency measurements
    always @(posedge clock) cyc++;

    // Memory-side stall, either forced by the test or random
    always @(posedge clock) begin
        #2;
        wait_line = rand_wait ? ($urandom_range(0, 2) == 0) : stall;
    end

    // Records every write that the memory will accept at the next edge
    always @(negedge clock) begin
        wr_t e;
        if (reset_n && bus.write && !bus.waitrequest) begin
            e.a  = bus.address;
            e.d  = bus.writedata;
            e.be = bus.byteenable;
            e.c  = cyc;
            obs.push_back(e);
        end
    end

    // Stops a hung run
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_pixel(input logic [23:0] idx, input logic [31:0] col, input logic bb);
        int n;
        n = 0;
        pixel_valid = 1'b1;
        pixel_index = idx;
        pixel_color = col;
        back_buffer = bb;
        @(negedge clock);
        while (!pixel_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        n_checks++;
        if (pixel_ready !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL pixel_accept idx=%0d: pixel_ready=%b, required 1 within 200 cycles", idx, pixel_ready);
        end
        @(posedge clock);
        #1;
        acc_cyc = cyc;
        pixel_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
    endtask

    task automatic wait_obs(input int n, input string what);
        int k;
        k = 0;
        while (obs.size() < n && k < 200) begin
            @(negedge clock);
            #1;
            k++;
        end
        n_checks++;
        if (obs.size() < n) begin
            n_fails++;
            $display("[TB] FAIL %s write count: got %0d, required at least %0d", what, obs.size(), n);
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #3;
        n_checks++;
        if ({bus.write, bus.address, bus.writedata, bus.byteenable, pixel_ready, clear_busy, debug_value} !== '0) begin
            n_fails++;
            $display("[TB] FAIL reset_outputs: write=%b addr=%h data=%h be=%h ready=%b busy=%b dbg=%0d, required all zero",
                     bus.write, bus.address, bus.writedata, bus.byteenable, pixel_ready, clear_busy, debug_value);
        end
        n_checks++;
        if (bus.burstcount !== 8'h01) begin
            n_fails++;
            $display("[TB] FAIL burstcount: got %h, required 01", bus.burstcount);
        end
        idle(2);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({pixel_ready, bus.write} !== 2'b10) begin
            n_fails++;
            $display("[TB] FAIL post_reset: ready=%b write=%b, required ready=1 write=0", pixel_ready, bus.write);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_pair();
        obs.delete();
        dbg0 = debug_value;
        send_pixel(24'd4, 32'h11111111, 1'b0);
        send_pixel(24'd5, 32'h22222222, 1'b0);
        wait_obs(1, "pair");
        idle(FLUSH + 4);
        n_checks++;
        if (obs.size() != 1) begin
            n_fails++;
            $display("[TB] FAIL pair_count: got %0d writes, required 1", obs.size());
        end
        if (obs.size() >= 1) begin
            n_checks++;
            if ({obs[0].a, obs[0].d, obs[0].be} !== {29'd2, 64'h22222222_11111111, 8'hFF}) begin
                n_fails++;
                $display("[TB] FAIL pair_word: got addr=%0d data=%h be=%h, required addr=2 data=2222222211111111 be=ff",
                         obs[0].a, obs[0].d, obs[0].be);
            end
        end
        n_checks++;
        if (debug_value - dbg0 !== 32'd1) begin
            n_fails++;
            $display("[TB] FAIL pair_debug: got delta %0d, required 1", debug_value - dbg0);
        end
        $display("[TB] test_pair done");
    endtask

    task automatic test_idle_flush();
        int lat;
        obs.delete();
        send_pixel(24'd3, 32'hDEADBEEF, 1'b1);
        wait_obs(1, "idle_flush");
        idle(2);
        if (obs.size() >= 1) begin
            lat = obs[0].c - acc_cyc;
            n_checks++;
            if ({obs[0].a, obs[0].be, obs[0].d[63:32]} !== {29'd9, 8'hF0, 32'hDEADBEEF}) begin
                n_fails++;
                $display("[TB] FAIL idle_word: got addr=%0d be=%h hi=%h, required addr=9 be=f0 hi=deadbeef",
                         obs[0].a, obs[0].be, obs[0].d[63:32]);
            end
            n_checks++;
            if (lat < int'(FLUSH) || lat > int'(FLUSH) + 2) begin
                n_fails++;
                $display("[TB] FAIL idle_latency: got %0d cycles, required %0d..%0d", lat, FLUSH, FLUSH + 2);
            end
        end
        obs.delete();
        send_pixel(24'd3, 32'h0BADF00D, 1'b1);
        pulse_flush();
        wait_obs(1, "force_flush");
        if (obs.size() >= 1) begin
            lat = obs[0].c - acc_cyc;
            n_checks++;
            if ({obs[0].a, obs[0].be, obs[0].d[63:32]} !== {29'd9, 8'hF0, 32'h0BADF00D}) begin
                n_fails++;
                $display("[TB] FAIL flush_word: got addr=%0d be=%h hi=%h, required addr=9 be=f0 hi=0badf00d",
                         obs[0].a, obs[0].be, obs[0].d[63:32]);
            end
            n_checks++;
            if (lat < 1 || lat > 2) begin
                n_fails++;
                $display("[TB] FAIL flush_latency: got %0d cycles, required 1..2", lat);
            end
        end
        $display("[TB] test_idle_flush done");
    endtask

    task automatic test_order();
        logic [28:0] ea[3];
        logic [7:0]  eb[3];
        logic [31:0] ec[3];
        ea = '{29'd0, 29'd1, 29'd0};
        eb = '{8'h0F, 8'h0F, 8'hF0};
        ec = '{32'hA0A0A0A0, 32'hA2A2A2A2, 32'hA1A1A1A1};
        obs.delete();
        send_pixel(24'd0, 32'hA0A0A0A0, 1'b0);
        send_pixel(24'd2, 32'hA2A2A2A2, 1'b0);
        send_pixel(24'd1, 32'hA1A1A1A1, 1'b0);
        wait_obs(3, "order");
        idle(FLUSH + 4);
        n_checks++;
        if (obs.size() != 3) begin
            n_fails++;
            $display("[TB] FAIL order_count: got %0d writes, required 3", obs.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < obs.size()) begin
                n_checks++;
                if ({obs[i].a, obs[i].be, (eb[i] == 8'h0F) ? obs[i].d[31:0] : obs[i].d[63:32]} !== {ea[i], eb[i], ec[i]}) begin
                    n_fails++;
                    $display("[TB] FAIL order_write%0d: got addr=%0d be=%h data=%h, required addr=%0d be=%h lane=%h",
                             i, obs[i].a, obs[i].be, obs[i].d, ea[i], eb[i], ec[i]);
                end
            end
        end
        $display("[TB] test_order done");
    endtask

    task automatic test_stall();
        int n;
        obs.delete();
        dbg0 = debug_value;
        stall = 1'b1;
        idle(1);
        send_pixel(24'd8, 32'h5A5A0001, 1'b0);
        pulse_flush();
        pixel_valid = 1'b1;
        pixel_index = 24'd10;
        pixel_color = 32'h5A5A0002;
        back_buffer = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_checks++;
            if ({bus.write, bus.address, bus.byteenable, bus.writedata[31:0], pixel_ready, debug_value}
                !== {1'b1, 29'd4, 8'h0F, 32'h5A5A0001, 1'b0, dbg0}) begin
                n_fails++;
                $display("[TB] FAIL stall_hold%0d: write=%b addr=%0d be=%h lo=%h ready=%b dbg=%0d, required 1/4/0f/5a5a0001/0/%0d",
                         i, bus.write, bus.address, bus.byteenable, bus.writedata[31:0], pixel_ready, debug_value, dbg0);
            end
        end
        @(posedge clock);
        #1 stall = 1'b0;
        n = 0;
        @(negedge clock);
        while (!pixel_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1 pixel_valid = 1'b0;
        pulse_flush();
        wait_obs(2, "stall");
        idle(3);
        n_checks++;
        if (obs.size() != 2) begin
            n_fails++;
            $display("[TB] FAIL stall_count: got %0d writes, required 2", obs.size());
        end else begin
            n_checks++;
            if ({obs[0].a, obs[0].be, obs[0].d[31:0], obs[1].a, obs[1].be, obs[1].d[31:0]}
                !== {29'd4, 8'h0F, 32'h5A5A0001, 29'd5, 8'h0F, 32'h5A5A0002}) begin
                n_fails++;
                $display("[TB] FAIL stall_words: got %0d/%h/%h then %0d/%h/%h, required 4/0f/5a5a0001 then 5/0f/5a5a0002",
                         obs[0].a, obs[0].be, obs[0].d[31:0], obs[1].a, obs[1].be, obs[1].d[31:0]);
            end
        end
        n_checks++;
        if (debug_value - dbg0 !== 32'd2) begin
            n_fails++;
            $display("[TB] FAIL stall_debug: got delta %0d, required 2", debug_value - dbg0);
        end
        $display("[TB] test_stall done");
    endtask

    task automatic test_clear();
        int k;
        obs.delete();
        dbg0 = debug_value;
        send_pixel(24'd0, 32'hCAFEF00D, 1'b1);
        clear_color = 32'h00FF00FF;
        back_buffer = 1'b1;
        clear_start = 1'b1;
        @(posedge clock);
        #1;
        clear_start = 1'b0;
        back_buffer = 1'b0;
        clear_color = '0;
        @(negedge clock);
        n_checks++;
        if ({clear_busy, pixel_ready} !== 2'b10) begin
            n_fails++;
            $display("[TB] FAIL clear_enter: busy=%b ready=%b, required busy=1 ready=0", clear_busy, pixel_ready);
        end
        wait_obs(3, "clear_mid");
        clear_color = 32'h12345678;
        clear_start = 1'b1;
        @(posedge clock);
        #1;
        clear_start = 1'b0;
        k = 0;
        while (clear_busy && k < 100) begin
            @(negedge clock);
            k++;
        end
        n_checks++;
        if ({clear_busy, pixel_ready} !== 2'b01) begin
            n_fails++;
            $display("[TB] FAIL clear_exit: busy=%b ready=%b, required busy=0 ready=1", clear_busy, pixel_ready);
        end
        idle(4);
        n_checks++;
        if (obs.size() != 9) begin
            n_fails++;
            $display("[TB] FAIL clear_count: got %0d writes, required 9", obs.size());
        end
        if (obs.size() >= 1) begin
            n_checks++;
            if ({obs[0].a, obs[0].be, obs[0].d[31:0]} !== {29'd8, 8'h0F, 32'hCAFEF00D}) begin
                n_fails++;
                $display("[TB] FAIL clear_drain: got addr=%0d be=%h lo=%h, required addr=8 be=0f lo=cafef00d",
                         obs[0].a, obs[0].be, obs[0].d[31:0]);
            end
        end
        for (int i = 1; i < 9; i++) begin
            if (i < obs.size()) begin
                n_checks++;
                if ({obs[i].a, obs[i].be, obs[i].d} !== {29'(7 + i), 8'hFF, 64'h00FF00FF_00FF00FF}) begin
                    n_fails++;
                    $display("[TB] FAIL clear_word%0d: got addr=%0d be=%h data=%h, required addr=%0d be=ff data=00ff00ff00ff00ff",
                             i, obs[i].a, obs[i].be, obs[i].d, 7 + i);
                end
            end
        end
        n_checks++;
        if (debug_value - dbg0 !== 32'd9) begin
            n_fails++;
            $display("[TB] FAIL clear_debug: got delta %0d, required 9", debug_value - dbg0);
        end
        $display("[TB] test_clear done");
    endtask

    task automatic test_reset_mid();
        obs.delete();
        stall = 1'b1;
        clear_color = 32'hA5A5A5A5;
        back_buffer = 1'b0;
        clear_start = 1'b1;
        @(posedge clock);
        #1 clear_start = 1'b0;
        idle(4);
        @(negedge clock);
        n_checks++;
        if ({bus.write, clear_busy} !== 2'b11) begin
            n_fails++;
            $display("[TB] FAIL midclear_busy: write=%b busy=%b, required 1/1", bus.write, clear_busy);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.write, clear_busy, pixel_ready} !== 3'b000) begin
            n_fails++;
            $display("[TB] FAIL async_reset: write=%b busy=%b ready=%b, required 0/0/0", bus.write, clear_busy, pixel_ready);
        end
        @(posedge clock);
        #1 stall = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        idle(1);
        n_checks++;
        if (debug_value !== 32'd0 || obs.size() != 0) begin
            n_fails++;
            $display("[TB] FAIL reset_debug: dbg=%0d writes=%0d, required 0/0", debug_value, obs.size());
        end
        send_pixel(24'd5, 32'h77665544, 1'b0);
        pulse_flush();
        wait_obs(1, "after_reset");
        idle(2);
        if (obs.size() >= 1) begin
            n_checks++;
            if ({obs[0].a, obs[0].be, obs[0].d[63:32]} !== {29'd2, 8'hF0, 32'h77665544}) begin
                n_fails++;
                $display("[TB] FAIL after_reset_word: got addr=%0d be=%h hi=%h, required addr=2 be=f0 hi=77665544",
                         obs[0].a, obs[0].be, obs[0].d[63:32]);
            end
        end
        n_checks++;
        if (debug_value !== 32'd1) begin
            n_fails++;
            $display("[TB] FAIL after_reset_debug: got %0d, required 1", debug_value);
        end
        $display("[TB] test_reset_mid done");
    endtask

    task automatic test_random();
        logic [23:0] idx;
        logic [31:0] col;
        logic        bb;
        logic [63:0] w;
        logic [63:0] mask;
        int          a;
        int          gap;
        obs.delete();
        m_data.delete();
        m_be.delete();
        d_data.delete();
        d_be.delete();
        dbg0 = debug_value;
        rand_wait = 1'b1;
        for (int i = 0; i < 150; i++) begin
            idx = 24'($urandom_range(0, 19));
            col = $urandom;
            bb  = 1'($urandom_range(0, 1));
            send_pixel(idx, col, bb);
            if (idx < 24'(LENGTH / 4)) begin
                a = int'(bb) * int'(LENGTH / 8) + int'(idx) / 2;
                w = m_data.exists(a) ? m_data[a] : 64'd0;
                if (idx[0]) w[63:32] = col;
                else        w[31:0]  = col;
                m_data[a] = w;
                m_be[a] = (m_be.exists(a) ? m_be[a] : 8'h00) | (idx[0] ? 8'hF0 : 8'h0F);
            end
            gap = $urandom_range(0, 6);
            if (gap > 0) begin
                flush = ($urandom_range(0, 3) == 0);
                idle(gap);
                flush = 1'b0;
            end
        end
        flush = 1'b1;
        idle(30);
        flush = 1'b0;
        rand_wait = 1'b0;
        idle(6);
        foreach (obs[i]) begin
            a = int'(obs[i].a);
            w = d_data.exists(a) ? d_data[a] : 64'd0;
            for (int b = 0; b < 8; b++)
                if (obs[i].be[b]) w[b*8 +: 8] = obs[i].d[b*8 +: 8];
            d_data[a] = w;
            d_be[a] = (d_be.exists(a) ? d_be[a] : 8'h00) | obs[i].be;
        end
        foreach (m_data[k]) begin
            mask = '0;
            for (int b = 0; b < 8; b++) mask[b*8 +: 8] = {8{m_be[k][b]}};
            n_checks++;
            if (!d_data.exists(k)) begin
                n_fails++;
                $display("[TB] FAIL random_word%0d: never written, required data=%h be=%h", k, m_data[k], m_be[k]);
            end else if (d_be[k] !== m_be[k] || (d_data[k] & mask) !== (m_data[k] & mask)) begin
                n_fails++;
                $display("[TB] FAIL random_word%0d: got data=%h be=%h, required data=%h be=%h",
                         k, d_data[k] & mask, d_be[k], m_data[k] & mask, m_be[k]);
            end
        end
        n_checks++;
        if (d_data.num() != m_data.num()) begin
            n_fails++;
            $display("[TB] FAIL random_extent: got %0d words written, required %0d", d_data.num(), m_data.num());
        end
        n_checks++;
        if (debug_value - dbg0 !== 32'(obs.size())) begin
            n_fails++;
            $display("[TB] FAIL random_debug: got delta %0d, required %0d", debug_value - dbg0, obs.size());
        end
        $display("[TB] test_random done");
    endtask

    // Runs the scenarios in sequence and reports the totals
    initial begin
        test_reset();
        test_pair();
        test_idle_flush();
        test_order();
        test_stall();
        test_clear();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
